clmul_seq: RTL
==============

// Module: clmul_seq
// PURPOSE
//  Bit-serial carry-less (GF(2)[x]) multiplier: one b-bit per cycle, shift-and-XOR.
//  Produces the unreduced 2*DATA_WIDTH-bit product of two polynomials of degree < polyn_grade.
//  Producer side of the reduction stage. prod_out/op_finish drive reduc_in/op_enable of the
//  sequential reducer; polyn_grade is shared with it.
// PARAMETERS
//  DATA_WIDTH  4  max field degree m; operand width; product bus is 2*DATA_WIDTH bits
// PORTS
//  clk          in   1                     rising-edge clock
//  rst          in   1                     async, active-high reset
//  op_enable    in   1                     0 = synchronous abort/clear; 1 = operate
//  start        in   1                     request; sampled only in IDLE
//  polyn_grade  in   $clog2(DATA_WIDTH)+1  field degree g; must be stable from start to op_finish
//  a_in         in   DATA_WIDTH            operand A, bit i = coeff of x^i
//  b_in         in   DATA_WIDTH            operand B, bit i = coeff of x^i
//  busy         out  1                     high in RUN and DONE
//  prod_out     out  2*DATA_WIDTH          A*B over GF(2); MSB always 0
//  op_finish    out  1                     one-cycle pulse: prod_out valid
// BEHAVIOUR
//  Reset: async on rst. state=IDLE; busy=0, op_finish=0, prod_out=0; acc and operand regs=0.
//  FSM states: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: on an edge with start=1 and op_enable=1:
//   - latch a_reg/b_reg = a_in/b_in with bits >= g forced to 0;
//   - acc=0, k=0, g_eff latched; go to RUN.
//  g_eff: g>DATA_WIDTH uses DATA_WIDTH; g<2 uses g_eff=1 with operands forced to 0, so result=0.
//  RUN: each edge
//   - if b_reg[k]: acc ^= (a_reg << k), zero-extended to 2*DATA_WIDTH;
//   - k++.
//   On the edge processing k=g_eff-1: prod_out <= final acc value; go to DONE.
//  DONE: op_finish=1 and busy=1 for exactly one cycle; next edge -> IDLE, op_finish=0.
//  Latency: start sampled at edge 0; op_finish high in the cycle after edge g_eff.
//   Example: g=4 -> high between edges 4 and 5.
//  Throughput: new start accepted at earliest in the cycle after op_finish (in IDLE).
//   Start in IDLE at the same edge DONE->IDLE occurs is not seen.
//  start while busy: ignored, no queuing; operands and result unaffected.
//  prod_out: registered; holds its value after op_finish until the next accepted start.
//   Accepted start clears prod_out to 0 at edge 0.
//  op_enable=0 (synchronous, any state): next edge -> IDLE, busy=0, op_finish=0, prod_out=0, acc=0.
//   op_enable=0 wins over a simultaneous start.
//  rst asserted mid-RUN: immediate abort to reset values; no op_finish for the aborted op.
//  Width rules: max product degree 2*g-2, so bits [2*DATA_WIDTH-1 : 2*g-1] of prod_out are 0.
//   a_reg<<k never exceeds 2*DATA_WIDTH-2; no truncation.
//  polyn_grade changing during RUN: undefined result, but FSM must still terminate within
//   DATA_WIDTH RUN cycles.
// TESTING (DATA_WIDTH=4)
//  1. g=4, a=4'b1011, b=4'b0110, start 1 cycle -> op_finish 4 cycles after start edge;
//     prod_out=8'b00111010; busy high for 5 cycles.
//  2. g=4, a=b=4'hF -> prod_out=8'b01010101 (squaring, cross terms cancel).
//  3. g=3, a=4'hF, b=4'b1101 -> operands masked to 3'b111, 3'b101;
//     prod_out=8'b00011011; op_finish 3 cycles after start.
//  4. Second start pulse while busy -> ignored; one op_finish only; result of first op held;
//     next start after IDLE works.
//  5. rst pulse 2 cycles into g=4 op -> all outputs 0 immediately, no op_finish.
//     op_enable=0 mid-run -> same at next edge.
//  6. g=0 or g=1 with a=b=4'hF -> op_finish after 1 cycle, prod_out=0.
//     Random a, b, g in 2..4 vs a software clmul model, 1000 ops.

Source files
------------

// File: rtl/clmul_seq.sv
// Bit-serial carry-less multiplier over GF(2)[x].
// Consumes one bit of B per RUN cycle and XORs the correspondingly shifted
// copy of A into a double-width accumulator. The result is the unreduced
// product and is handed to the sequential reducer via prod_out/op_finish.
module clmul_seq #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          op_enable,
    input  logic                          start,
    input  logic [$clog2(DATA_WIDTH):0]   polyn_grade,
    input  logic [DATA_WIDTH-1:0]         a_in,
    input  logic [DATA_WIDTH-1:0]         b_in,
    output logic                          busy,
    output logic [2*DATA_WIDTH-1:0]       prod_out,
    output logic                          op_finish
);

    localparam int GW = $clog2(DATA_WIDTH) + 1;
    localparam int KW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int PW = 2 * DATA_WIDTH;
    localparam logic [GW-1:0] G_MAX = GW'(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] a_reg;
    logic [DATA_WIDTH-1:0] b_reg;
    logic [PW-1:0]         acc;
    logic [KW-1:0]         k;
    logic [KW-1:0]         last_k;

    logic [GW-1:0]         g_eff_c;
    logic                  opnd_ok;
    logic [DATA_WIDTH-1:0] mask;
    logic [KW-1:0]         last_k_c;
    logic [PW-1:0]         shifted;
    logic [PW-1:0]         next_acc;

    // Clamp the requested degree and build the operand mask. Degrees below 2
    // run a single dummy cycle with zeroed operands so the result is 0; the
    // last bit index is latched at start so a changing polyn_grade during RUN
    // cannot stretch the operation.
    always_comb begin
        g_eff_c = polyn_grade;
        opnd_ok = 1'b1;
        if (polyn_grade > G_MAX) begin
            g_eff_c = G_MAX;
        end else if (polyn_grade < GW'(2)) begin
            g_eff_c = GW'(1);
            opnd_ok = 1'b0;
        end
        mask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            mask[i] = opnd_ok && (i < int'(g_eff_c));
        end
        last_k_c = KW'(g_eff_c - GW'(1));
    end

    // One shift-and-XOR step: A is zero-extended before shifting, so the
    // highest term (degree 2*DATA_WIDTH-2) always fits without truncation.
    always_comb begin
        shifted  = {{DATA_WIDTH{1'b0}}, a_reg} << k;
        next_acc = acc ^ (b_reg[k] ? shifted : '0);
    end

    // Control FSM with registered outputs; op_enable=0 clears everything and
    // takes priority over a simultaneous start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            k         <= '0;
            last_k    <= '0;
            busy      <= 1'b0;
            op_finish <= 1'b0;
            prod_out  <= '0;
        end else if (!op_enable) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            k         <= '0;
            busy      <= 1'b0;
            op_finish <= 1'b0;
            prod_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    op_finish <= 1'b0;
                    if (start) begin
                        a_reg    <= a_in & mask;
                        b_reg    <= b_in & mask;
                        acc      <= '0;
                        k        <= '0;
                        last_k   <= last_k_c;
                        prod_out <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc <= next_acc;
                    if (k == last_k) begin
                        prod_out  <= next_acc;
                        op_finish <= 1'b1;
                        state     <= DONE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE: begin
                    op_finish <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    op_finish <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
